bb_dot_mac: RTL and testbench
=============================

# bb_dot_mac

Parametrised, precision-scalable, bit-blade dot-product MAC with framed accumulation. Each cycle it takes LANES byte-lanes per operand and splits every byte into four 2-bit blades. In mode-selected element width (8/4/2-bit), signed or unsigned per operand, it forms the full dot product and accumulates it over a first..last group into a saturating accumulator. Sits in the PE array in place of the fixed 8x8 blade adder tree, feeding the output collector with one result per group.

## Interface
- LANES, default 4: byte-lanes per operand per cycle.
- ACC_W, default 24: signed accumulator / result width.
- CNT_W, default 16: group sample-count width.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  in  1  sample present this cycle.
- in_first  in  1  sample opens a group (clears accumulator, count, ovf).
- in_last  in  1  sample closes a group (result emitted).
- in_mode  in  2  00 = 8-bit, 01 = 4-bit, 10 = 2-bit, 11 = treated as 8-bit.
- in_sa, in_sb  in  1 each  operand a / b elements are two's complement.
- in_a, in_b  in  8*LANES  packed operands; lane l = bits 8l+7:8l, element e of a lane = low-order first.
- out_valid  out  1  one-cycle pulse: group result valid.
- out_data  out  ACC_W  signed group result.
- out_count  out  CNT_W  samples in group, saturating at all-ones.
- out_ovf  out  1  accumulator saturated at least once in group.

## Operation
- Blade k of a lane = bits 2k+1:2k, k=0..3. Blade extended to 3 bits: MSB = blade[1] & sign & top, where top = k==3 (8-bit), k odd (4-bit), always (2-bit).
- Pair (i,j) product = 3bx3b signed, 6-bit. Included and shifted per mode: 8-bit, all 16 pairs, shift 2(i+j); 4-bit, pairs with i/2==j/2, shift 2((i%2)+(j%2)); 2-bit, i==j, shift 0.
- Lane sum = sum of included shifted products. Sample sum = sum over lanes. SUM_W = 18+clog2(LANES), signed, exact.
- Mode, signs and framing flags travel with each sample. Mode may change between samples, including inside a group.
- Accumulate: base = in_first ? 0 : acc. acc <= sat(base + sum) to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Set ovf on clamp, sticky; ovf is cleared by first.
- Count: first loads 1, otherwise increments and saturates at all-ones.
- in_valid low = bubble: no state change beyond pipeline advance.
- in_first with a group open: partial group discarded silently.
- in_first and in_last on the same sample: single-sample group.
- Samples before any first (or after reset) accumulate onto acc=0, count=0.

## Timing
- Three-stage pipeline, no backpressure, one sample per cycle.
  - S1 registers the blade-pair products.
  - S2 registers the sample sum.
  - S3 updates acc/count/ovf.
- Sample with in_valid&in_last captured at edge E: out_valid is high for exactly the cycle following edge E+3.
  - out_data, out_count and out_ovf reflect the post-update group state.
  - These outputs hold their value until the next out_valid.
- Back-to-back groups (last at E, first at E+1) produce consecutive out_valid pulses; no cycle lost.
- Reset: all pipeline valid bits, acc, count, ovf, out_valid, out_data, out_count, out_ovf = 0. In-flight samples are dropped.

## Structure
- Shared package bb_pkg: mode encodings (BB_MODE_8/4/2), blade width 2, SUM_W function of LANES, saturation helper function.
- Sub-module bb_blade_2x2: one extended-blade pair product (sx,x1,x0,sy,y1,y0 -> 6-bit signed), instantiated 16*LANES times.

## Test plan
- LANES=4, mode 00, sa=sb=1, a bytes 0x80, b bytes 0x7F, first=last=1 -> out_data = -65024 (0xFF0200), count 1, ovf 0, out_valid at E+3.
- Mode 01 unsigned, a=b=0xFFFFFFFF -> 8 products x225 = 1800. Mode 10, sa=sb=1, a=b=0xAAAAAAAA -> 64. Mode 10, sa=1, sb=0, a=0xAAAAAAAA, b=0xFFFFFFFF -> -96.
- Group of 3 samples (mode 00 unsigned, 1x1 per lane each) with bubbles between -> 12, count 3. Immediately following group gives its own independent result.
- Saturation: mode 00 unsigned 0xFF x 0xFF, 33-sample group -> out_data 0x7FFFFF, ovf 1. Next group -> ovf 0 and correct sum.
- Mode change mid-group (00 then 10 samples) -> sum of per-mode results. first mid-group discards the earlier partial.
- rst_n low while a group is in flight -> all outputs 0, no out_valid. Post-reset samples without first accumulate from 0.

Source files
------------

// File: rtl/bb_pkg.sv
// ============================================================================
// bb_pkg : shared encodings and helpers for the bit-blade dot-product MAC
// Rev 1.0
// ============================================================================
`default_nettype none

package bb_pkg;

    typedef enum logic [1:0] {
        BB_MODE_8  = 2'b00,
        BB_MODE_4  = 2'b01,
        BB_MODE_2  = 2'b10,
        BB_MODE_8X = 2'b11
    } bb_mode_e;

    localparam int BB_BLADE_W = 2;
    localparam int BB_BLADES  = 4;
    localparam int BB_PROD_W  = 6;

    function automatic int bb_sum_w(input int lanes);
        return 18 + $clog2(lanes);
    endfunction

    // Blade k carries the element sign bit when it is the top blade of its element.
    function automatic logic bb_blade_top(input bb_mode_e m, input int k);
        case (m)
            BB_MODE_4: return (k % 2) == 1;
            BB_MODE_2: return 1'b1;
            default:   return k == 3;
        endcase
    endfunction

    function automatic logic bb_pair_used(input bb_mode_e m, input int i, input int j);
        case (m)
            BB_MODE_4: return (i / 2) == (j / 2);
            BB_MODE_2: return i == j;
            default:   return 1'b1;
        endcase
    endfunction

    function automatic int bb_pair_shift(input bb_mode_e m, input int i, input int j);
        case (m)
            BB_MODE_4: return 2 * ((i % 2) + (j % 2));
            BB_MODE_2: return 0;
            default:   return 2 * (i + j);
        endcase
    endfunction

    function automatic logic signed [63:0] bb_sat(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bb_dot_mac_if.sv
// ============================================================================
// bb_dot_mac_if : sample input / group result bundle of bb_dot_mac
// Rev 1.0
// ============================================================================
`default_nettype none

interface bb_dot_mac_if #(
    parameter int LANES = 4,
    parameter int ACC_W = 24,
    parameter int CNT_W = 16
);
    logic               in_valid;
    logic               in_first;
    logic               in_last;
    logic [1:0]         in_mode;
    logic               in_sa;
    logic               in_sb;
    logic [8*LANES-1:0] in_a;
    logic [8*LANES-1:0] in_b;
    logic               out_valid;
    logic [ACC_W-1:0]   out_data;
    logic [CNT_W-1:0]   out_count;
    logic               out_ovf;

    modport master (
        output in_valid, in_first, in_last, in_mode, in_sa, in_sb, in_a, in_b,
        input  out_valid, out_data, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_first, in_last, in_mode, in_sa, in_sb, in_a, in_b,
        output out_valid, out_data, out_count, out_ovf
    );
endinterface

`default_nettype wire

// File: rtl/bb_blade_2x2.sv
// ============================================================================
// bb_blade_2x2 : signed product of two sign-extended 2-bit blades
// Rev 1.0
// ============================================================================
`default_nettype none

module bb_blade_2x2 (
    input  logic              sx,
    input  logic              x1,
    input  logic              x0,
    input  logic              sy,
    input  logic              y1,
    input  logic              y0,
    output logic signed [5:0] p
);
    logic signed [2:0] w_x;
    logic signed [2:0] w_y;

    assign w_x = {sx, x1, x0};
    assign w_y = {sy, y1, y0};
    // Range is -6..9, so a 6-bit signed result is exact.
    assign p   = 6'(w_x) * 6'(w_y);
endmodule

`default_nettype wire

// File: rtl/bb_dot_mac.sv
// ============================================================================
// bb_dot_mac : precision-scalable bit-blade dot-product MAC, framed accumulate
// Rev 1.0
// ============================================================================
`default_nettype none

module bb_dot_mac
    import bb_pkg::*;
#(
    parameter int LANES = 4,
    parameter int ACC_W = 24,
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    bb_dot_mac_if.slave  bus
);
    localparam int SUM_W = bb_sum_w(LANES);

    bb_mode_e w_mode;
    logic [BB_BLADES-1:0] w_top;
    logic [LANES-1:0][BB_BLADES-1:0][BB_BLADES-1:0][BB_PROD_W-1:0] w_prod;

    assign w_mode = bb_mode_e'(bus.in_mode);

    always_comb begin
        w_top = '0;
        for (int k = 0; k < BB_BLADES; k++) begin
            w_top[k] = bb_blade_top(w_mode, k);
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        for (genvar i = 0; i < BB_BLADES; i++) begin : g_i
            for (genvar j = 0; j < BB_BLADES; j++) begin : g_j
                bb_blade_2x2 u_blade (
                    .sx (bus.in_a[8*l + BB_BLADE_W*i + 1] & bus.in_sa & w_top[i]),
                    .x1 (bus.in_a[8*l + BB_BLADE_W*i + 1]),
                    .x0 (bus.in_a[8*l + BB_BLADE_W*i]),
                    .sy (bus.in_b[8*l + BB_BLADE_W*j + 1] & bus.in_sb & w_top[j]),
                    .y1 (bus.in_b[8*l + BB_BLADE_W*j + 1]),
                    .y0 (bus.in_b[8*l + BB_BLADE_W*j]),
                    .p  (w_prod[l][i][j])
                );
            end
        end
    end

    // ---------------- S1: raw blade-pair products ----------------
    logic     r1_valid;
    logic     r1_first;
    logic     r1_last;
    bb_mode_e r1_mode;
    logic [LANES-1:0][BB_BLADES-1:0][BB_BLADES-1:0][BB_PROD_W-1:0] r1_prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid <= 1'b0;
        end else begin
            r1_valid <= bus.in_valid;
        end
    end

    always_ff @(posedge clk) begin
        r1_first <= bus.in_first;
        r1_last  <= bus.in_last;
        r1_mode  <= w_mode;
        r1_prod  <= w_prod;
    end

    // ---------------- S2: mode-selected, shifted sample sum ----------------
    logic signed [SUM_W-1:0] w_sum;
    logic                    r2_valid;
    logic                    r2_first;
    logic                    r2_last;
    logic signed [SUM_W-1:0] r2_sum;

    always_comb begin
        w_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int i = 0; i < BB_BLADES; i++) begin
                for (int j = 0; j < BB_BLADES; j++) begin
                    if (bb_pair_used(r1_mode, i, j)) begin
                        w_sum = w_sum + (SUM_W'($signed(r1_prod[l][i][j]))
                                         <<< bb_pair_shift(r1_mode, i, j));
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_valid <= 1'b0;
        end else begin
            r2_valid <= r1_valid;
        end
    end

    always_ff @(posedge clk) begin
        r2_first <= r1_first;
        r2_last  <= r1_last;
        r2_sum   <= w_sum;
    end

    // ---------------- S3: saturating group accumulator ----------------
    logic signed [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_ovf;
    logic                    r_emit;
    logic signed [ACC_W-1:0] w_base;
    logic signed [63:0]      w_total;
    logic signed [63:0]      w_sat;
    logic                    w_clamp;

    assign w_base  = r2_first ? '0 : r_acc;
    assign w_total = $signed({{(64-ACC_W){w_base[ACC_W-1]}}, w_base})
                   + $signed({{(64-SUM_W){r2_sum[SUM_W-1]}}, r2_sum});
    assign w_sat   = bb_sat(w_total, ACC_W);
    assign w_clamp = (w_sat != w_total);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            r_emit <= 1'b0;
        end else begin
            r_emit <= r2_valid & r2_last;
            if (r2_valid) begin
                r_acc <= w_sat[ACC_W-1:0];
                r_ovf <= r2_first ? w_clamp : (r_ovf | w_clamp);
                if (r2_first) begin
                    r_cnt <= CNT_W'(1);
                end else if (!(&r_cnt)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    // ---------------- Result registers, held until the next pulse ----------------
    logic             r_out_valid;
    logic [ACC_W-1:0] r_out_data;
    logic [CNT_W-1:0] r_out_count;
    logic             r_out_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            r_out_valid <= r_emit;
            if (r_emit) begin
                r_out_data  <= r_acc;
                r_out_count <= r_cnt;
                r_out_ovf   <= r_ovf;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_count = r_out_count;
    assign bus.out_ovf   = r_out_ovf;

endmodule

`default_nettype wire

// File: tb/tb_bb_dot_mac.sv
// ============================================================================
// tb_bb_dot_mac : vector table plus group sequences, checked via result queue
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bb_dot_mac;
    localparam int LANES = 4;
    localparam int ACC_W = 24;
    localparam int CNT_W = 16;
    localparam longint ACC_MAX = (64'sd1 <<< (ACC_W - 1)) - 1;
    localparam longint ACC_MIN = -(64'sd1 <<< (ACC_W - 1));

    logic clk;
    logic rst_n;
    longint cyc;
    int total;
    int bad;

    bb_dot_mac_if #(.LANES(LANES), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    bb_dot_mac #(.LANES(LANES), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [ACC_W-1:0] data;
        logic [CNT_W-1:0] cnt;
        logic             ovf;
        longint           cap;
    } exp_t;

    typedef struct {
        logic [1:0]  mode;
        logic        sa;
        logic        sb;
        logic [31:0] a;
        logic [31:0] b;
        longint      exp;
    } vec_t;

    exp_t   sbq[$];
    longint m_acc;
    longint m_cnt;
    bit     m_ovf;
    logic [ACC_W-1:0] last_data;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Element-wise reference: slice each lane into elements and multiply directly.
    function automatic longint dot(input logic [1:0] mode, input bit sa, input bit sb,
                                   input logic [31:0] a, input logic [31:0] b);
        int ew;
        longint s, ea, eb, msk;
        ew  = (mode == 2'b01) ? 4 : (mode == 2'b10) ? 2 : 8;
        msk = (longint'(1) << ew) - 1;
        s   = 0;
        for (int p = 0; p < 32; p += ew) begin
            ea = longint'(a >> p) & msk;
            eb = longint'(b >> p) & msk;
            if (sa && ea[ew-1]) ea -= (longint'(1) << ew);
            if (sb && eb[ew-1]) eb -= (longint'(1) << ew);
            s += ea * eb;
        end
        return s;
    endfunction

    task automatic send(input bit f, input bit l, input logic [1:0] mode, input bit sa,
                        input bit sb, input logic [31:0] a, input logic [31:0] b,
                        input bit has_exp, input longint exp);
        longint t;
        exp_t   e;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_first = f;
        bus.in_last  = l;
        bus.in_mode  = mode;
        bus.in_sa    = sa;
        bus.in_sb    = sb;
        bus.in_a     = a;
        bus.in_b     = b;
        t = (f ? 0 : m_acc) + dot(mode, sa, sb, a, b);
        if (f) begin
            m_cnt = 1;
            m_ovf = 1'b0;
        end else if (m_cnt != (1 << CNT_W) - 1) begin
            m_cnt++;
        end
        if (t > ACC_MAX) begin
            t = ACC_MAX;
            m_ovf = 1'b1;
        end else if (t < ACC_MIN) begin
            t = ACC_MIN;
            m_ovf = 1'b1;
        end
        m_acc = t;
        if (l) begin
            e.data = has_exp ? exp[ACC_W-1:0] : t[ACC_W-1:0];
            e.cnt  = m_cnt[CNT_W-1:0];
            e.ovf  = m_ovf;
            e.cap  = cyc + 1;
            sbq.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_first = 1'($urandom);
            bus.in_last  = 1'($urandom);
            bus.in_a     = $urandom;
            bus.in_b     = $urandom;
        end
    endtask

    task automatic drain();
        idle(1);
        for (int k = 0; k < 40 && sbq.size() != 0; k++) idle(1);
        chk("drain_timeout", 64'(sbq.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.out_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
                e = sbq.pop_front();
                chk("latency",   64'(cyc),           64'(e.cap + 3));
                chk("out_data",  64'(bus.out_data),  64'(e.data));
                chk("out_count", 64'(bus.out_count), 64'(e.cnt));
                chk("out_ovf",   64'(bus.out_ovf),   64'(e.ovf));
                last_data = e.data;
            end
        end
    end

    vec_t vt[10];

    initial begin
        total = 0;
        bad   = 0;
        m_acc = 0;
        m_cnt = 0;
        m_ovf = 1'b0;
        last_data = '0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_mode  = 2'b00;
        bus.in_sa    = 1'b0;
        bus.in_sb    = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;

        vt[0] = '{2'b00, 1'b1, 1'b1, 32'h80808080, 32'h7F7F7F7F, -65024};
        vt[1] = '{2'b01, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1800};
        vt[2] = '{2'b10, 1'b1, 1'b1, 32'hAAAAAAAA, 32'hAAAAAAAA, 64};
        vt[3] = '{2'b10, 1'b1, 1'b0, 32'hAAAAAAAA, 32'hFFFFFFFF, -96};
        vt[4] = '{2'b11, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h01010101, -4};
        vt[5] = '{2'b00, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 260100};
        vt[6] = '{2'b01, 1'b1, 1'b1, 32'h88888888, 32'h77777777, -448};
        vt[7] = '{2'b00, 1'b1, 1'b1, 32'h80808080, 32'h80808080, 65536};
        vt[8] = '{2'b10, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 144};
        vt[9] = '{2'b01, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, -120};

        repeat (3) @(negedge clk);
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_out_data",  64'(bus.out_data),  64'd0);
        chk("reset_out_count", 64'(bus.out_count), 64'd0);
        chk("reset_out_ovf",   64'(bus.out_ovf),   64'd0);
        rst_n = 1'b1;

        // Single-sample groups, issued back to back.
        for (int i = 0; i < 10; i++) begin
            send(1, 1, vt[i].mode, vt[i].sa, vt[i].sb, vt[i].a, vt[i].b, 1, vt[i].exp);
        end
        drain();
        idle(3);
        chk("hold_out_data",  64'(bus.out_data),  64'(last_data));
        chk("hold_out_valid", 64'(bus.out_valid), 64'd0);

        // Three-sample group with bubbles, then an independent group.
        send(1, 0, 2'b00, 0, 0, 32'h01010101, 32'h01010101, 0, 0);
        idle(2);
        send(0, 0, 2'b00, 0, 0, 32'h01010101, 32'h01010101, 0, 0);
        idle(1);
        send(0, 1, 2'b00, 0, 0, 32'h01010101, 32'h01010101, 1, 12);
        send(1, 1, 2'b00, 0, 0, 32'h02020202, 32'h03030303, 1, 24);

        // Saturation across 33 samples, then a clean group.
        for (int i = 0; i < 33; i++) begin
            send(i == 0, i == 32, 2'b00, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, i == 32, 64'h7FFFFF);
        end
        send(1, 1, 2'b01, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1800);

        // Mode change inside a group: 8-bit 1x1 lanes (4) plus 2-bit 0xAA signed (64).
        send(1, 0, 2'b00, 0, 0, 32'h01010101, 32'h01010101, 0, 0);
        send(0, 1, 2'b10, 1, 1, 32'hAAAAAAAA, 32'hAAAAAAAA, 1, 68);

        // A new first abandons the open partial group.
        send(1, 0, 2'b00, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
        send(0, 0, 2'b00, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
        send(1, 1, 2'b10, 1, 0, 32'hAAAAAAAA, 32'hFFFFFFFF, 1, -96);
        drain();

        // Randomised samples and framing against the element-wise model.
        for (int i = 0; i < 40; i++) begin
            send(i == 0 || $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                 2'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, 0, 0);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        drain();

        // Reset while a group is in flight: nothing may emerge.
        send(1, 1, 2'b00, 0, 0, 32'h05050505, 32'h05050505, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        sbq.delete();
        m_acc = 0;
        m_cnt = 0;
        m_ovf = 1'b0;
        @(negedge clk);
        chk("midreset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midreset_out_data",  64'(bus.out_data),  64'd0);
        chk("midreset_out_count", 64'(bus.out_count), 64'd0);
        chk("midreset_out_ovf",   64'(bus.out_ovf),   64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(5);

        // Post-reset sample without first accumulates from zero, count 1.
        send(0, 1, 2'b00, 0, 0, 32'h02020202, 32'h02020202, 1, 16);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
